// File: rtl/goertzel_bin_scheduler_if.sv
// -----------------------------------------------------------------------------
// goertzel_bin_scheduler_if
//
// Purpose: bundles the control/data signals between the bin scheduler and the
// single Goertzel engine that it time-multiplexes across tone bins.
//
// Signals:
//   eng_en    scheduler -> engine  engine enable
//   eng_start scheduler -> engine  one-cycle start pulse for the current bin
//   eng_sin   scheduler -> engine  sin coefficient of the current bin (D_W)
//   eng_cos   scheduler -> engine  cos coefficient of the current bin (D_W)
//   eng_done  engine -> scheduler  completion pulse
//   eng_mag   engine -> scheduler  unsigned magnitude, valid with eng_done
//
// Modports:
//   master  the scheduler side
//   slave   the engine side
// -----------------------------------------------------------------------------
interface goertzel_bin_scheduler_if #(
  parameter int unsigned D_W = 16
) ();

  logic           eng_en;
  logic           eng_start;
  logic [D_W-1:0] eng_sin;
  logic [D_W-1:0] eng_cos;
  logic           eng_done;
  logic [D_W-1:0] eng_mag;

  modport master (
    output eng_en,
    output eng_start,
    output eng_sin,
    output eng_cos,
    input  eng_done,
    input  eng_mag
  );

  modport slave (
    input  eng_en,
    input  eng_start,
    input  eng_sin,
    input  eng_cos,
    output eng_done,
    output eng_mag
  );

endinterface : goertzel_bin_scheduler_if

// File: rtl/goertzel_bin_scheduler.sv
// -----------------------------------------------------------------------------
// goertzel_bin_scheduler
//
// Purpose: runs one Goertzel engine over N_BINS tone bins for every filled
// sample bank. For each bin it loads the sin/cos coefficients, pulses the
// engine start, waits for the magnitude and keeps the strongest bin. After
// the last bin it reports the strongest bin index as a symbol together with a
// carrier-detect flag (strongest magnitude >= thresh).
//
// Optional feature macro: GOERTZEL_SCHED_WATCHDOG_EN
//   defined   : a WAIT-state watchdog aborts a frame after WD_CYCLES cycles
//               without eng_done and pulses timeout.
//   undefined : no watchdog; timeout is tied low and WAIT waits forever.
//
// Ports:
//   sys_clk      in   sole clock, rising edge
//   sys_rst_n    in   asynchronous active-low reset
//   frame_ready  in   one-cycle pulse, a sample bank is full
//   thresh       in   carrier threshold (D_W), sampled in the final EVAL
//   eng          if   engine bus (master modport): en/start/sin/cos out,
//                     done/mag in
//   busy         out  high whenever the scheduler is not idle
//   result_valid out  one-cycle pulse, symbol/carrier_det updated
//   symbol       out  index of the strongest bin (SYM_W)
//   carrier_det  out  strongest magnitude >= thresh
//   overrun      out  one-cycle pulse, a frame_ready was dropped
//   timeout      out  one-cycle pulse, the watchdog aborted a frame
// -----------------------------------------------------------------------------
module goertzel_bin_scheduler #(
  parameter int unsigned           D_W       = 16,
  parameter int unsigned           N_BINS    = 4,
  parameter int unsigned           SYM_W     = 2,
  parameter logic [N_BINS*D_W-1:0] SIN_TABLE = {(N_BINS*D_W){1'b0}},
  parameter logic [N_BINS*D_W-1:0] COS_TABLE = {(N_BINS*D_W){1'b0}},
  parameter int unsigned           WD_CYCLES = 4096
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     frame_ready,
  input  logic [D_W-1:0]           thresh,
  goertzel_bin_scheduler_if.master eng,
  output logic                     busy,
  output logic                     result_valid,
  output logic [SYM_W-1:0]         symbol,
  output logic                     carrier_det,
  output logic                     overrun,
  output logic                     timeout
);

  // State encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_EVAL   = 3'd4;
  localparam logic [2:0] ST_REPORT = 3'd5;

  localparam logic [SYM_W-1:0] LAST_BIN = SYM_W'(N_BINS - 1);
  localparam logic [SYM_W-1:0] BIN_ONE  = SYM_W'(1'b1);

  // Reject configurations the bin counter or the watchdog cannot represent.
  if ((N_BINS < 2) || (N_BINS > (1 << SYM_W)) || (WD_CYCLES < 1)) begin : g_bad_cfg
    $error("goertzel_bin_scheduler: unsupported parameter combination");
  end

  // Coefficient of bin idx from a packed table (bin k at [k*D_W +: D_W]).
  function automatic logic [D_W-1:0] coef_at(
    input logic [N_BINS*D_W-1:0] tbl,
    input logic [SYM_W-1:0]      idx
  );
    coef_at = tbl[idx*D_W +: D_W];
  endfunction

  logic [2:0]       state_q,        state_d;
  logic [SYM_W-1:0] bin_q,          bin_d;
  logic [D_W-1:0]   cur_mag_q,      cur_mag_d;
  logic [D_W-1:0]   best_mag_q,     best_mag_d;
  logic [SYM_W-1:0] best_idx_q,     best_idx_d;
  logic [D_W-1:0]   eng_sin_q,      eng_sin_d;
  logic [D_W-1:0]   eng_cos_q,      eng_cos_d;
  logic             eng_en_q,       eng_en_d;
  logic             eng_start_q,    eng_start_d;
  logic             busy_q,         busy_d;
  logic             result_valid_q, result_valid_d;
  logic [SYM_W-1:0] symbol_q,       symbol_d;
  logic             carrier_det_q,  carrier_det_d;
  logic             overrun_q,      overrun_d;

`ifdef GOERTZEL_SCHED_WATCHDOG_EN
  // Counter runs 0 .. WD_CYCLES-1 across the WAIT cycles of one bin.
  localparam int unsigned     WD_W    = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1'b1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_q, timeout_d;
`endif

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d        = state_q;
    bin_d          = bin_q;
    cur_mag_d      = cur_mag_q;
    best_mag_d     = best_mag_q;
    best_idx_d     = best_idx_q;
    eng_sin_d      = eng_sin_q;
    eng_cos_d      = eng_cos_q;
    eng_start_d    = 1'b0;
    result_valid_d = 1'b0;
    symbol_d       = symbol_q;
    carrier_det_d  = carrier_det_q;
    // Any frame_ready while a frame is in flight (REPORT included) is dropped.
    overrun_d      = frame_ready && (state_q != ST_IDLE);
`ifdef GOERTZEL_SCHED_WATCHDOG_EN
    wd_cnt_d       = wd_cnt_q;
    timeout_d      = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (frame_ready) begin
          best_mag_d = {D_W{1'b0}};
          best_idx_d = {SYM_W{1'b0}};
          bin_d      = {SYM_W{1'b0}};
          eng_sin_d  = coef_at(SIN_TABLE, {SYM_W{1'b0}});
          eng_cos_d  = coef_at(COS_TABLE, {SYM_W{1'b0}});
          state_d    = ST_LOAD;
        end else begin
          state_d    = ST_IDLE;
        end
      end

      ST_LOAD: begin
        // Coefficients have settled for a cycle; start is registered so it
        // is high exactly while the state is START.
        state_d     = ST_START;
        eng_start_d = 1'b1;
      end

      ST_START: begin
        state_d = ST_WAIT;
`ifdef GOERTZEL_SCHED_WATCHDOG_EN
        wd_cnt_d = {WD_W{1'b0}};
`endif
      end

      ST_WAIT: begin
        if (eng.eng_done) begin
          // Done on the expiry cycle still wins over the watchdog.
          cur_mag_d = eng.eng_mag;
          state_d   = ST_EVAL;
        end else begin
`ifdef GOERTZEL_SCHED_WATCHDOG_EN
          if (wd_cnt_q == WD_LAST) begin
            state_d   = ST_IDLE;
            timeout_d = 1'b1;
          end else begin
            wd_cnt_d  = wd_cnt_q + WD_ONE;
          end
`else
          state_d = ST_WAIT;
`endif
        end
      end

      ST_EVAL: begin
        // Strictly greater: on ties the earlier (lower) bin is kept.
        if (cur_mag_q > best_mag_q) begin
          best_mag_d = cur_mag_q;
          best_idx_d = bin_q;
        end else begin
          best_mag_d = best_mag_q;
          best_idx_d = best_idx_q;
        end

        if (bin_q == LAST_BIN) begin
          // Result is latched here so thresh is the value seen in this EVAL.
          state_d        = ST_REPORT;
          result_valid_d = 1'b1;
          symbol_d       = best_idx_d;
          carrier_det_d  = (best_mag_d >= thresh);
        end else begin
          bin_d       = bin_q + BIN_ONE;
          eng_sin_d   = coef_at(SIN_TABLE, bin_q + BIN_ONE);
          eng_cos_d   = coef_at(COS_TABLE, bin_q + BIN_ONE);
          state_d     = ST_START;
          eng_start_d = 1'b1;
        end
      end

      ST_REPORT: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Engine enable and busy follow the state being entered.
    eng_en_d = (state_d == ST_LOAD) || (state_d == ST_START) ||
               (state_d == ST_WAIT) || (state_d == ST_EVAL);
    busy_d   = (state_d != ST_IDLE);
  end

  // State and datapath registers; everything returns to zero on reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q        <= ST_IDLE;
      bin_q          <= {SYM_W{1'b0}};
      cur_mag_q      <= {D_W{1'b0}};
      best_mag_q     <= {D_W{1'b0}};
      best_idx_q     <= {SYM_W{1'b0}};
      eng_sin_q      <= {D_W{1'b0}};
      eng_cos_q      <= {D_W{1'b0}};
      eng_en_q       <= 1'b0;
      eng_start_q    <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      symbol_q       <= {SYM_W{1'b0}};
      carrier_det_q  <= 1'b0;
      overrun_q      <= 1'b0;
`ifdef GOERTZEL_SCHED_WATCHDOG_EN
      wd_cnt_q       <= {WD_W{1'b0}};
      timeout_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      bin_q          <= bin_d;
      cur_mag_q      <= cur_mag_d;
      best_mag_q     <= best_mag_d;
      best_idx_q     <= best_idx_d;
      eng_sin_q      <= eng_sin_d;
      eng_cos_q      <= eng_cos_d;
      eng_en_q       <= eng_en_d;
      eng_start_q    <= eng_start_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      symbol_q       <= symbol_d;
      carrier_det_q  <= carrier_det_d;
      overrun_q      <= overrun_d;
`ifdef GOERTZEL_SCHED_WATCHDOG_EN
      wd_cnt_q       <= wd_cnt_d;
      timeout_q      <= timeout_d;
`endif
    end
  end

  assign eng.eng_en    = eng_en_q;
  assign eng.eng_start = eng_start_q;
  assign eng.eng_sin   = eng_sin_q;
  assign eng.eng_cos   = eng_cos_q;

  assign busy          = busy_q;
  assign result_valid  = result_valid_q;
  assign symbol        = symbol_q;
  assign carrier_det   = carrier_det_q;
  assign overrun       = overrun_q;

`ifdef GOERTZEL_SCHED_WATCHDOG_EN
  assign timeout       = timeout_q;
`else
  assign timeout       = 1'b0;
`endif

endmodule : goertzel_bin_scheduler

// File: tb/tb_goertzel_bin_scheduler.sv
// -----------------------------------------------------------------------------
// tb_goertzel_bin_scheduler
//
// Self-checking bench for goertzel_bin_scheduler. A behavioural engine answers
// each start pulse with a queued magnitude; expected symbol/carrier results
// are pushed to a scoreboard when a frame is launched and popped when the
// scheduler reports. Covers reset, normal frames, ties, threshold boundary,
// overrun, back-to-back frames, the WAIT watchdog (or its absence) and a reset
// in the middle of WAIT.
// -----------------------------------------------------------------------------
module tb_goertzel_bin_scheduler;

  localparam int D_W       = 16;
  localparam int N_BINS    = 4;
  localparam int SYM_W     = 2;
  localparam int WD_CYCLES = 64;
  localparam logic [N_BINS*D_W-1:0] SIN_T = 64'h3B21_2D41_187E_0C8C;
  localparam logic [N_BINS*D_W-1:0] COS_T = 64'h187E_2D41_3B21_3EC5;

  typedef struct {
    logic [SYM_W-1:0] sym;
    logic             det;
  } exp_t;

  logic             sys_clk     = 1'b0;
  logic             sys_rst_n   = 1'b0;
  logic             frame_ready = 1'b0;
  logic [D_W-1:0]   thresh      = '0;
  logic             busy;
  logic             result_valid;
  logic [SYM_W-1:0] symbol;
  logic             carrier_det;
  logic             overrun;
  logic             timeout;

  goertzel_bin_scheduler_if #(.D_W(D_W)) eng_if ();

  goertzel_bin_scheduler #(
    .D_W      (D_W),
    .N_BINS   (N_BINS),
    .SYM_W    (SYM_W),
    .SIN_TABLE(SIN_T),
    .COS_TABLE(COS_T),
    .WD_CYCLES(WD_CYCLES)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .frame_ready (frame_ready),
    .thresh      (thresh),
    .eng         (eng_if),
    .busy        (busy),
    .result_valid(result_valid),
    .symbol      (symbol),
    .carrier_det (carrier_det),
    .overrun     (overrun),
    .timeout     (timeout)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_starts = 0;
  int   n_results = 0;
  int   n_expected = 0;
  int   n_overrun = 0;
  int   n_timeout = 0;
  int   exp_bin = 0;
  int   hold_bin = -1;
  int   eng_lat = 3;
  int   last_done_cyc = 0;
  int   wait_entry_cyc = 0;
  exp_t exp_q[$];
  int   mag_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [D_W-1:0] tbl_word(input logic [N_BINS*D_W-1:0] t, input int k);
    return t[k*D_W +: D_W];
  endfunction

  // Behavioural engine: checks coefficients on each start, answers after eng_lat cycles.
  initial begin : engine_model
    int mag;
    eng_if.eng_done = 1'b0;
    eng_if.eng_mag  = '0;
    forever begin
      @(negedge sys_clk);
      eng_if.eng_done = 1'b0;
      if (eng_if.eng_start === 1'b1) begin
        check_val("eng_sin", eng_if.eng_sin, tbl_word(SIN_T, exp_bin));
        check_val("eng_cos", eng_if.eng_cos, tbl_word(COS_T, exp_bin));
        n_starts++;
        wait_entry_cyc = cyc + 1;
        if (exp_bin == hold_bin) begin
          exp_bin++;
        end else if (mag_q.size() == 0) begin
          check_val("mag_available", mag_q.size(), 1);
          exp_bin++;
        end else begin
          mag = mag_q.pop_front();
          exp_bin++;
          repeat (eng_lat) @(negedge sys_clk);
          eng_if.eng_mag  = D_W'(mag);
          eng_if.eng_done = 1'b1;
          last_done_cyc   = cyc;
        end
      end
    end
  end

  // Result monitor: pops the scoreboard on every result_valid, counts pulses.
  initial begin : result_monitor
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (result_valid === 1'b1) begin
        n_results++;
        check_val("result_latency", cyc - last_done_cyc, 2);
        if (exp_q.size() == 0) begin
          check_val("unexpected_result", result_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check_val("symbol", symbol, e.sym);
          check_val("carrier_det", carrier_det, e.det);
        end
      end
      if (overrun === 1'b1) n_overrun++;
      if (timeout === 1'b1) n_timeout++;
    end
  end

  // Queue magnitudes for one frame and, if a result is due, its expectation.
  task automatic queue_frame(input int m0, input int m1, input int m2, input int m3,
                             input int thr, input bit expect_result);
    int   m[4];
    int   best;
    exp_t e;
    m = '{m0, m1, m2, m3};
    best = 0;
    e.sym = '0;
    for (int k = 0; k < 4; k++) begin
      if (m[k] > best) begin
        best  = m[k];
        e.sym = SYM_W'(k);
      end
      mag_q.push_back(m[k]);
    end
    e.det  = (best >= thr);
    thresh = D_W'(thr);
    exp_bin = 0;
    if (expect_result) begin
      exp_q.push_back(e);
      n_expected++;
    end
  endtask

  // Pulse frame_ready for one cycle starting at the current negedge.
  task automatic pulse_now();
    frame_ready = 1'b1;
    @(negedge sys_clk);
    frame_ready = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if (busy === 1'b0) break;
    end
    check_val("idle_reached", busy, 1'b0);
  endtask

  task automatic run_frame(input int m0, input int m1, input int m2, input int m3, input int thr);
    queue_frame(m0, m1, m2, m3, thr, 1'b1);
    @(negedge sys_clk);
    pulse_now();
    wait_idle(300);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"},     busy,             1'b0);
    check_val({tag, "_rvalid"},   result_valid,     1'b0);
    check_val({tag, "_symbol"},   symbol,           '0);
    check_val({tag, "_carrier"},  carrier_det,      1'b0);
    check_val({tag, "_overrun"},  overrun,          1'b0);
    check_val({tag, "_timeout"},  timeout,          1'b0);
    check_val({tag, "_eng_en"},   eng_if.eng_en,    1'b0);
    check_val({tag, "_eng_start"},eng_if.eng_start, 1'b0);
    check_val({tag, "_eng_sin"},  eng_if.eng_sin,   '0);
    check_val({tag, "_eng_cos"},  eng_if.eng_cos,   '0);
  endtask

  initial begin : stimulus
    int starts0, ovr0, res0, i;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_all_zero("reset");
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // Normal frame with entry timing.
    queue_frame(100, 900, 300, 200, 500, 1'b1);
    pulse_now();
    check_val("busy_t1", busy, 1'b1);
    check_val("eng_en_load", eng_if.eng_en, 1'b1);
    check_val("no_start_in_load", eng_if.eng_start, 1'b0);
    @(negedge sys_clk);
    check_val("start_t2", eng_if.eng_start, 1'b1);
    wait_idle(300);
    check_val("normal_starts", n_starts, 4);
    check_val("normal_results", n_results, 1);
    check_val("eng_en_idle", eng_if.eng_en, 1'b0);
    check_val("sin_hold", eng_if.eng_sin, tbl_word(SIN_T, 3));

    // Ties and threshold boundary.
    run_frame(400, 50, 400, 10, 401);
    run_frame(400, 50, 400, 10, 400);
    run_frame(0, 0, 0, 0, 0);
    run_frame(1, 2, 3, 65535, 65535);

    // Randomised frames with frequent ties.
    for (int r = 0; r < 6; r++) begin
      run_frame(100 * $urandom_range(0, 7), 100 * $urandom_range(0, 7),
                100 * $urandom_range(0, 7), 100 * $urandom_range(0, 7),
                $urandom_range(0, 800));
    end

    // Overrun during WAIT of bin 2 and during REPORT.
    eng_lat = 6;
    starts0 = n_starts;
    ovr0    = n_overrun;
    queue_frame(10, 20, 30, 40, 25, 1'b1);
    @(negedge sys_clk);
    pulse_now();
    for (i = 0; i < 200 && exp_bin < 3; i++) @(negedge sys_clk);
    @(negedge sys_clk);
    check_val("ovr_busy_in_wait", busy, 1'b1);
    pulse_now();
    for (i = 0; i < 200 && result_valid !== 1'b1; i++) @(negedge sys_clk);
    check_val("ovr_report_seen", result_valid, 1'b1);
    pulse_now();
    repeat (10) @(negedge sys_clk);
    check_val("overrun_count", n_overrun - ovr0, 2);
    check_val("no_second_frame", busy, 1'b0);
    check_val("ovr_starts", n_starts - starts0, 4);
    eng_lat = 3;

    // Back-to-back: new frame accepted in the first IDLE cycle.
    ovr0 = n_overrun;
    queue_frame(5, 6, 7, 8, 8, 1'b1);
    @(negedge sys_clk);
    pulse_now();
    for (i = 0; i < 200 && result_valid !== 1'b1; i++) @(negedge sys_clk);
    check_val("b2b_report_seen", result_valid, 1'b1);
    queue_frame(9, 1, 1, 1, 10, 1'b1);
    @(negedge sys_clk);
    check_val("b2b_idle_gap", busy, 1'b0);
    pulse_now();
    check_val("b2b_accept", busy, 1'b1);
    wait_idle(300);
    check_val("b2b_no_overrun", n_overrun - ovr0, 0);

    // Engine never answers bin 1.
    hold_bin = 1;
    res0 = n_results;
    queue_frame(3000, 2000, 0, 0, 100, 1'b0);
    @(negedge sys_clk);
    pulse_now();
`ifdef GOERTZEL_SCHED_WATCHDOG_EN
    for (i = 0; i < 300 && timeout !== 1'b1; i++) @(negedge sys_clk);
    check_val("timeout_pulse", timeout, 1'b1);
    check_val("timeout_latency", cyc - wait_entry_cyc, WD_CYCLES);
    check_val("wd_busy_low", busy, 1'b0);
    check_val("wd_eng_en_low", eng_if.eng_en, 1'b0);
    repeat (5) @(negedge sys_clk);
    check_val("wd_timeout_count", n_timeout, 1);
    check_val("wd_no_result", n_results - res0, 0);
    mag_q.delete();
    queue_frame(3000, 2000, 0, 0, 100, 1'b0);
    @(negedge sys_clk);
    pulse_now();
    repeat (20) @(negedge sys_clk);
`else
    repeat (100) @(negedge sys_clk);
    check_val("wait_forever_busy", busy, 1'b1);
    check_val("wait_forever_en", eng_if.eng_en, 1'b1);
    check_val("no_timeout", n_timeout, 0);
`endif

    // Asynchronous reset in the middle of WAIT.
    check_val("pre_reset_busy", busy, 1'b1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    mag_q.delete();
    hold_bin = -1;
    check_val("midreset_no_result", n_results - res0, 0);
    run_frame(5, 3, 7, 1, 6);
    run_frame(2, 4, 1, 3, 5);

    repeat (5) @(negedge sys_clk);
    check_val("scoreboard_drained", exp_q.size(), 0);
    check_val("result_count", n_results, n_expected);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : global_timeout
    #500000;
    $display("FAIL global_timeout: got no end of test expected finish by 500000");
    $fatal(1, "simulation time limit");
  end

endmodule : tb_goertzel_bin_scheduler
